// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: word-aligned memory access, sub-word extract/extend, RMW sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word accesses trap instead of silently aligning.
module lsu_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
`ifdef MISALIGN_TRAP_EN
  logic              mis_q, mis_d;
  logic              req_mis;
`endif

  logic              req_illegal;
  logic [4:0]        bsh;
  logic [DATA_W-1:0] shifted, ext, merged;
  logic [15:0]       half;

  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
  assign req_mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

  // Lane extraction for loads and lane replacement for RMW stores.
  assign bsh     = {addr_q[1:0], 3'b000};
  assign shifted = mem_rdata >> bsh;
  assign half    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ext    = mem_rdata;
    merged = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        ext    = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
        merged = old_q;
        merged[bsh +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        ext    = {{16{~f3_q[2] & half[15]}}, half};
        merged = old_q;
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        ext    = mem_rdata;
        merged = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        if (req_illegal) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
`ifdef MISALIGN_TRAP_EN
        else if (req_mis) begin
          err_d   = 1'b1;
          mis_d   = 1'b1;
          state_d = RESP;
        end
`endif
        else if (req_we && (req_funct3 == 3'b010)) state_d = WRITE;
        else state_d = READ;
      end
      READ: begin
        if (we_q) begin
          old_d   = mem_rdata;
          state_d = WRITE;
        end else begin
          rdata_d = ext;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  // Reset arriving mid-WRITE must not corrupt memory.
  assign mem_en     = (state_q == WRITE) & ~rst;
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = (state_q == WRITE) ? merged : '0;
`ifdef MISALIGN_TRAP_EN
  assign misaligned = mis_q;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: vector table through a scoreboard, plus hold-high and reset-in-WRITE sequences.
module tb_lsu_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err, mem_en;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  assign mem_rdata = mem[mem_addr[15:2]];
  always @(posedge clk) if (mem_en) mem[mem_addr[15:2]] <= mem_wdata;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        wr;
    logic [31:0] wexp;
    logic        mis;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
    bit   wseen;
  } sb_t;

  vec_t pend_q[$];
  sb_t  sb_q[$];
  vec_t tv[$];
  int   errors = 0, checks = 0, cyc = 0;

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [15:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic err, int lat, logic wr,
                              logic [31:0] wexp, logic mis);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd; v.err = err;
    v.lat = lat; v.wr = wr; v.wexp = wexp; v.mis = mis;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() != 0) chk("ready_busy", {31'b0, req_ready}, 32'd0);
      if (mem_en) begin
        if (sb_q.size() == 0) chk("spurious_write", 32'd1, 32'd0);
        else begin
          chk("write_expected", {31'b0, sb_q[0].v.wr}, 32'd1);
          chk("mem_wdata", mem_wdata, sb_q[0].v.wexp);
          chk("mem_addr", {16'b0, mem_addr}, {16'b0, sb_q[0].v.addr[15:2], 2'b00});
          chk("single_write", {31'b0, sb_q[0].wseen}, 32'd0);
          sb_q[0].wseen = 1'b1;
        end
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
        else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("resp_rdata", resp_rdata, e.v.rd);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.v.err});
          chk("latency", cyc - e.acc, e.v.lat);
          chk("write_seen", {31'b0, e.wseen}, {31'b0, e.v.wr});
`ifdef MISALIGN_TRAP_EN
          chk("misaligned", {31'b0, misaligned}, {31'b0, e.v.mis});
`endif
        end
      end
      if (req_valid && req_ready) begin
        if (pend_q.size() == 0) chk("unexpected_accept", 32'd1, 32'd0);
        else begin
          sb_t e;
          e.v = pend_q.pop_front();
          e.acc = cyc;
          e.wseen = 1'b0;
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic send(vec_t v, bit keep);
    bit ok = 1'b0;
    pend_q.push_back(v);
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", {31'b0, ok}, 32'd1);
    if (!keep) begin
      @(posedge clk); #2;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0 && pend_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", sb_q.size() + pend_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[16'h0010 >> 2] = 32'h887766F5;
    mem[16'h0030 >> 2] = 32'h11223344;
    mem[16383]         = 32'hA5A55A5A;

    tv.push_back(mk(0, 3'b000, 16'h0010, 0, 32'hFFFFFFF5, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b100, 16'h0013, 0, 32'h00000088, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b001, 16'h0012, 0, 32'hFFFF8877, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b101, 16'h0010, 0, 32'h000066F5, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b010, 16'h0010, 0, 32'h887766F5, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b000, 16'h0011, 0, 32'h00000066, 0, 2, 0, 0, 0));
    tv.push_back(mk(1, 3'b000, 16'h0011, 32'h123456AB, 0, 0, 3, 1, 32'h8877ABF5, 0));
    tv.push_back(mk(0, 3'b010, 16'h0010, 0, 32'h8877ABF5, 0, 2, 0, 0, 0));
    tv.push_back(mk(1, 3'b010, 16'h0020, 32'hDEADBEEF, 0, 0, 2, 1, 32'hDEADBEEF, 0));
    tv.push_back(mk(0, 3'b010, 16'h0020, 0, 32'hDEADBEEF, 0, 2, 0, 0, 0));
    tv.push_back(mk(1, 3'b001, 16'h0022, 32'h0000CAFE, 0, 0, 3, 1, 32'hCAFEBEEF, 0));
    tv.push_back(mk(0, 3'b101, 16'h0022, 0, 32'h0000CAFE, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b011, 16'h0010, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(1, 3'b100, 16'h0010, 32'hFFFFFFFF, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 3'b110, 16'h0010, 0, 0, 1, 1, 0, 0, 0));
`ifdef MISALIGN_TRAP_EN
    tv.push_back(mk(0, 3'b010, 16'h0011, 0, 0, 1, 1, 0, 0, 1));
    tv.push_back(mk(0, 3'b001, 16'h0013, 0, 0, 1, 1, 0, 0, 1));
`else
    tv.push_back(mk(0, 3'b010, 16'h0011, 0, 32'h8877ABF5, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b001, 16'h0013, 0, 32'hFFFF8877, 0, 2, 0, 0, 0));
`endif
    tv.push_back(mk(0, 3'b100, 16'hFFFF, 0, 32'h000000A5, 0, 2, 0, 0, 0));

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    foreach (tv[i]) begin
      send(tv[i], 1'b0);
      drain();
    end

    // req_valid held high across several back-to-back requests.
    send(mk(0, 3'b010, 16'h0020, 0, 32'hCAFEBEEF, 0, 2, 0, 0, 0), 1'b1);
    send(mk(0, 3'b111, 16'h0020, 0, 0, 1, 1, 0, 0, 0), 1'b1);
    send(mk(1, 3'b000, 16'h0020, 32'h000000FF, 0, 0, 3, 1, 32'hCAFEBEFF, 0), 1'b1);
    send(mk(0, 3'b010, 16'h0020, 0, 32'hCAFEBEFF, 0, 2, 0, 0, 0), 1'b0);
    drain();

    // Reset during the WRITE cycle of an SH drops the op and leaves memory untouched.
    send(mk(1, 3'b001, 16'h0030, 32'h00005555, 0, 0, 3, 1, 32'h11225555, 0), 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("rstw_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rstw_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rstw_resp_valid2", {31'b0, resp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    chk("rstw_mem_word", mem[16'h0030 >> 2], 32'h11223344);
    send(mk(0, 3'b010, 16'h0030, 0, 32'h11223344, 0, 2, 0, 0, 0), 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting directly upstream of the data-memory port of the memory wrapper (clk, en, 16-bit byte addr, 32-bit write/read data).
- Accepts one RV32I load/store request at a time from the execute stage.
- Word-aligns the address and performs byte/halfword extraction with sign/zero extension.
- Implements sub-word stores as a read-modify-write of the 32-bit word.
- Returns a single-cycle response to the pipeline.

Parameters:
ADDR_W, 16, byte-address width toward data memory
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
req_addr  in  16  byte address
req_wdata  in  32  store data, rs2 value, right-aligned
resp_valid  out  1  one-cycle pulse when the operation completes
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_err  out  1  qualified by resp_valid; illegal funct3 (or misalignment, see Optional Feature)
mem_en  out  1  data-memory write enable
mem_addr  out  16  word-aligned byte address {addr[15:2],2'b00}
mem_wdata  out  32  data-memory write data
mem_rdata  in  32  data-memory read data, combinational from mem_addr

Behaviour:
- Reset values:
  - State IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_en=0, mem_addr=0, mem_wdata=0.
  - All latched request registers = 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - On accept, latch we, funct3, addr, wdata.
  - Legal load -> READ.
  - SW -> WRITE.
  - SB/SH -> READ.
  - Illegal combination -> RESP with err=1. Illegal means funct3 011/110/111, or store with funct3 100/101.
- READ:
  - mem_addr = latched word address; mem_rdata is sampled at the end of the cycle.
  - Load: extract and extend into resp_rdata register -> RESP.
  - Store: capture the old word -> WRITE.
- Byte lane selection:
  - Byte lane = addr[1:0].
  - Halfword lane = addr[1]; addr[0] is ignored.
  - Word ignores addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- WRITE:
  - mem_en=1 for exactly one cycle.
  - mem_wdata = old word with the selected lane replaced by req_wdata[7:0] or [15:0]; full req_wdata for SW.
  - Next state: RESP.
- RESP:
  - resp_valid=1 for one cycle, then IDLE.
  - req_ready=0 throughout; a new request is accepted in the cycle after RESP.
- Latency, counting from the accept edge to the cycle with resp_valid high:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
  - No back-to-back accepts; throughput is one operation per latency+1 cycles.
- mem_en is 0 in every state except WRITE. It is gated as WRITE & ~rst, so rst asserted during WRITE suppresses the write.
- rst in any state: next edge -> IDLE with all outputs at reset values. The in-flight request is dropped and produces no resp_valid.
- req_valid and req_* are ignored outside IDLE.
- Address wrap: none. 0xFFFC..0xFFFF map to word 0xFFFC.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, goes IDLE -> RESP with resp_err=1 and resp_rdata=0.
  - No memory read or write is performed.
  - An extra output port misaligned (1 bit) mirrors resp_err for this cause only.
- Undefined:
  - The misaligned port is absent.
  - Low address bits are silently ignored as described in Behaviour; no error is raised for misalignment.

Test Plan:
- Preload word 0x0010 = 0x887766F5. LB @0x0010 -> resp_rdata 0xFFFFFFF5, resp_valid 2 cycles after accept. LBU @0x0013 -> 0x00000088. LH @0x0012 -> 0xFFFF8877.
- SB @0x0011, wdata 0x123456AB -> one mem_en pulse with mem_wdata 0x8877ABF5; resp_valid 3 cycles after accept. A following LW @0x0010 returns 0x8877ABF5.
- SW @0x0020, wdata 0xDEADBEEF -> mem_en high exactly one cycle, mem_addr 0x0020; LW @0x0020 returns 0xDEADBEEF.
- req_valid held high continuously -> req_ready=0 from the cycle after accept until IDLE; exactly one resp_valid pulse per accepted request; no request is lost or duplicated.
- rst asserted in the WRITE cycle of SH @0x0030 -> no memory change, no resp_valid; req_ready=1 on the cycle after reset deasserts.
- funct3=011 load -> resp_err=1 one cycle after accept, no mem_en. With MISALIGN_TRAP_EN, LW @0x0011 -> resp_err=1 and misaligned=1, mem_en never asserted. Without it, LW @0x0011 returns the word at 0x0010.
